// File: rtl/tetris_pkg.sv
// tetris_pkg
// Shared constants and types for the Tetris board datapath.
//   BOARD_W / BOARD_H / CELL_W : board geometry and cell colour width
//   BOARD_CELLS, CELL_ADDR_W   : derived cell count and address width
//   cell_t                     : colour code stored in each board cell
//   owner_t                    : tag naming which port owns an in-flight read
package tetris_pkg;

  localparam int BOARD_W     = 10;
  localparam int BOARD_H     = 20;
  localparam int CELL_W      = 3;
  localparam int BOARD_CELLS = BOARD_W * BOARD_H;
  localparam int CELL_ADDR_W = $clog2(BOARD_CELLS);

  typedef enum logic [CELL_W-1:0] {
    EMPTY = 3'd0,
    I     = 3'd1,
    O     = 3'd2,
    T     = 3'd3,
    S     = 3'd4,
    Z     = 3'd5,
    J     = 3'd6,
    L     = 3'd7
  } cell_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_GAME = 2'd2
  } owner_t;

endpackage

// File: rtl/board_rsp_pipe.sv
// board_rsp_pipe
// Two-stage owner-tag pipeline that routes board RAM read data back to the
// port that issued the read.
//   Clk, Reset_n     : clock, asynchronous active-low reset
//   i_owner          : owner of the access granted this cycle
//   i_memRdata       : RAM read data (valid one cycle after the address)
//   o_vidRvalid/Rdata   : video response
//   o_gameRvalid/Rdata  : game response
module board_rsp_pipe
  import tetris_pkg::*;
#(
  parameter int DATA_W = CELL_W
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  owner_t            i_owner,
  input  logic [DATA_W-1:0] i_memRdata,
  output logic              o_vidRvalid,
  output logic [DATA_W-1:0] o_vidRdata,
  output logic              o_gameRvalid,
  output logic [DATA_W-1:0] o_gameRdata
);

  owner_t            r_tag1;
  owner_t            r_tag2;
  logic [DATA_W-1:0] r_vidRdata;
  logic [DATA_W-1:0] r_gameRdata;

  // Stage 1 remembers who owns the RAM access issued last cycle; when that
  // tag is live the RAM output belongs to that owner, so it is captured into
  // the owner's data register while the tag moves on to stage 2. The stage 2
  // tag then marks the cycle in which the captured data is presented.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_tag1      <= OWN_NONE;
      r_tag2      <= OWN_NONE;
      r_vidRdata  <= '0;
      r_gameRdata <= '0;
    end else begin
      r_tag1 <= i_owner;
      r_tag2 <= r_tag1;
      if (r_tag1 == OWN_VID) begin
        r_vidRdata <= i_memRdata;
      end
      if (r_tag1 == OWN_GAME) begin
        r_gameRdata <= i_memRdata;
      end
    end
  end

  assign o_vidRvalid  = (r_tag2 == OWN_VID);
  assign o_gameRvalid = (r_tag2 == OWN_GAME);
  assign o_vidRdata   = r_vidRdata;
  assign o_gameRdata  = r_gameRdata;

endmodule

// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter
// Arbitrates the single-port board RAM between the VGA colour mapper (fixed
// priority, read-only) and the game engine (reads and writes, starvation
// bounded by MAX_STALL consecutive lost contentions).
//   Clk, Reset_n                          : clock, asynchronous active-low reset
//   vid_req/vid_addr -> vid_gnt           : video read request and grant
//   vid_rvalid/vid_rdata                  : video read response (grant + 2)
//   game_req/we/addr/wdata -> game_gnt    : game request and grant
//   game_rvalid/game_rdata                : game read response (grant + 2)
//   mem_addr/mem_we/mem_wdata, mem_rdata  : board RAM port
module board_mem_arbiter
  import tetris_pkg::*;
#(
  parameter int ADDR_W    = CELL_ADDR_W,
  parameter int DATA_W    = CELL_W,
  parameter int MAX_STALL = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              game_req,
  input  logic              game_we,
  input  logic [ADDR_W-1:0] game_addr,
  input  logic [DATA_W-1:0] game_wdata,
  output logic              game_gnt,
  output logic              game_rvalid,
  output logic [DATA_W-1:0] game_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] STALL_LIMIT = 4'(MAX_STALL);

  logic [3:0] r_stallCnt;
  logic       w_gameWins;
  owner_t     w_owner;

  // The game port wins when it is alone, or when it has already lost
  // MAX_STALL contentions in a row. Grants are masked while reset is held so
  // no requester retires a request that the RAM never sees.
  always_comb begin
    w_gameWins = game_req & (~vid_req | (r_stallCnt == STALL_LIMIT));
    game_gnt   = Reset_n & w_gameWins;
    vid_gnt    = Reset_n & vid_req & ~w_gameWins;
  end

  // Counts consecutive cycles where the game engine waited behind video.
  // Any cycle without a game request, or a game grant, ends the streak.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_stallCnt <= '0;
    end else if (!game_req || game_gnt) begin
      r_stallCnt <= '0;
    end else if (vid_gnt && (r_stallCnt < STALL_LIMIT)) begin
      r_stallCnt <= r_stallCnt + 4'd1;
    end
  end

  // RAM port follows the granted requester; idle cycles drive zeros so the
  // RAM never sees a stray write. Video never writes.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    w_owner   = OWN_NONE;
    if (vid_gnt) begin
      mem_addr = vid_addr;
      w_owner  = OWN_VID;
    end else if (game_gnt) begin
      mem_addr  = game_addr;
      mem_we    = game_we;
      mem_wdata = game_wdata;
      w_owner   = game_we ? OWN_NONE : OWN_GAME;
    end
  end

  board_rsp_pipe #(
    .DATA_W(DATA_W)
  ) u_rspPipe (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .i_owner     (w_owner),
    .i_memRdata  (mem_rdata),
    .o_vidRvalid (vid_rvalid),
    .o_vidRdata  (vid_rdata),
    .o_gameRvalid(game_rvalid),
    .o_gameRdata (game_rdata)
  );

endmodule

// File: tb/tb_board_mem_arbiter.sv
// tb_board_mem_arbiter
// Drives directed and randomized traffic into board_mem_arbiter, emulates the
// board RAM, and compares every cycle against a transaction-level model.
module tb_board_mem_arbiter;

  localparam int MAX_STALL = 4;

  logic       Clk;
  logic       Reset_n;
  logic       vid_req;
  logic [7:0] vid_addr;
  logic       vid_gnt;
  logic       vid_rvalid;
  logic [2:0] vid_rdata;
  logic       game_req;
  logic       game_we;
  logic [7:0] game_addr;
  logic [2:0] game_wdata;
  logic       game_gnt;
  logic       game_rvalid;
  logic [2:0] game_rdata;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [2:0] mem_wdata;
  logic [2:0] mem_rdata;

  board_mem_arbiter #(
    .ADDR_W   (8),
    .DATA_W   (3),
    .MAX_STALL(MAX_STALL)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_gnt    (vid_gnt),
    .vid_rvalid (vid_rvalid),
    .vid_rdata  (vid_rdata),
    .game_req   (game_req),
    .game_we    (game_we),
    .game_addr  (game_addr),
    .game_wdata (game_wdata),
    .game_gnt   (game_gnt),
    .game_rvalid(game_rvalid),
    .game_rdata (game_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Free-running clock, 10 time units per cycle.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Board RAM stand-in: registered read, write visible to the next read.
  logic [2:0] ram [256];
  always @(posedge Clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model state: expected memory contents, outstanding responses
  // tagged with the cycle they are due, last data seen per port, and the
  // number of consecutive contentions the game port has lost.
  typedef struct {
    int       due;
    bit       isVid;
    logic [2:0] data;
  } rsp_t;

  rsp_t       rspQ[$];
  logic [2:0] modelMem [256];
  logic [2:0] lastVid;
  logic [2:0] lastGame;
  int         losses;
  int         cycleNo;
  int         errors;
  int         checks;
  bit         expVidGnt;
  bit         expGameGnt;
  bit         obsGameGnt;
  bit         obsGameRvalid;
  logic [2:0] obsGameRdata;
  int         waited;

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)",
               tag, observed, expected, cycleNo);
    end
  endtask

  // One clock cycle: at the falling edge compare all outputs against the
  // model, then advance the model by the arbitration rules and return just
  // after the next rising edge so the caller can drive new inputs.
  task automatic applyStimulus();
    bit   eVidValid;
    bit   eGameValid;
    bit   gameWins;
    rsp_t r;
    @(negedge Clk);
    eVidValid  = 1'b0;
    eGameValid = 1'b0;
    while (rspQ.size() > 0 && rspQ[0].due == cycleNo) begin
      r = rspQ.pop_front();
      if (r.isVid) begin
        eVidValid = 1'b1;
        lastVid   = r.data;
      end else begin
        eGameValid = 1'b1;
        lastGame   = r.data;
      end
    end
    gameWins   = game_req && (!vid_req || losses == MAX_STALL);
    expGameGnt = Reset_n && gameWins;
    expVidGnt  = Reset_n && vid_req && !gameWins;

    checkOutput("vid_gnt", 32'(vid_gnt), 32'(expVidGnt));
    checkOutput("game_gnt", 32'(game_gnt), 32'(expGameGnt));
    checkOutput("vid_rvalid", 32'(vid_rvalid), 32'(eVidValid));
    checkOutput("game_rvalid", 32'(game_rvalid), 32'(eGameValid));
    checkOutput("vid_rdata", 32'(vid_rdata), 32'(lastVid));
    checkOutput("game_rdata", 32'(game_rdata), 32'(lastGame));
    if (expVidGnt) begin
      checkOutput("mem_addr_vid", 32'(mem_addr), 32'(vid_addr));
      checkOutput("mem_we_vid", 32'(mem_we), 32'd0);
    end else if (expGameGnt) begin
      checkOutput("mem_addr_game", 32'(mem_addr), 32'(game_addr));
      checkOutput("mem_we_game", 32'(mem_we), 32'(game_we));
      checkOutput("mem_wdata_game", 32'(mem_wdata), 32'(game_wdata));
    end else begin
      checkOutput("mem_addr_idle", 32'(mem_addr), 32'd0);
      checkOutput("mem_we_idle", 32'(mem_we), 32'd0);
      checkOutput("mem_wdata_idle", 32'(mem_wdata), 32'd0);
    end
    obsGameGnt    = game_gnt;
    obsGameRvalid = game_rvalid;
    obsGameRdata  = game_rdata;

    if (!Reset_n || !game_req || expGameGnt) losses = 0;
    else if (losses < MAX_STALL) losses++;
    if (expVidGnt) begin
      r.due = cycleNo + 2; r.isVid = 1'b1; r.data = modelMem[vid_addr];
      rspQ.push_back(r);
    end else if (expGameGnt) begin
      if (game_we) begin
        modelMem[game_addr] = game_wdata;
      end else begin
        r.due = cycleNo + 2; r.isVid = 1'b0; r.data = modelMem[game_addr];
        rspQ.push_back(r);
      end
    end
    cycleNo++;
    @(posedge Clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    vid_req  = 1'b0;
    game_req = 1'b0;
    for (int k = 0; k < n; k++) applyStimulus();
  endtask

  // Holds a video stream against a pending game read and returns how many
  // cycles the game request waited until (and including) its grant.
  task automatic contendedRead(input logic [7:0] gAddr, output int n);
    n         = 0;
    vid_req   = 1'b1;
    game_req  = 1'b1;
    game_we   = 1'b0;
    game_addr = gAddr;
    for (int k = 1; k <= 20; k++) begin
      if (game_req) begin
        applyStimulus();
        if (expVidGnt) vid_addr = vid_addr + 8'd1;
        if (expGameGnt) game_req = 1'b0;
        if (obsGameGnt && n == 0) n = k;
      end
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    cycleNo  = 0;
    losses   = 0;
    lastVid  = '0;
    lastGame = '0;
    for (int i = 0; i < 256; i++) begin
      ram[i]      <= 3'(i % 8);
      modelMem[i]  = 3'(i % 8);
    end
    Reset_n    = 1'b0;
    vid_req    = 1'b0;
    vid_addr   = '0;
    game_req   = 1'b0;
    game_we    = 1'b0;
    game_addr  = '0;
    game_wdata = '0;
    #1;
    checkOutput("rst_vid_rvalid", 32'(vid_rvalid), 32'd0);
    checkOutput("rst_game_rvalid", 32'(game_rvalid), 32'd0);
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;

    // Idle after reset release.
    idleCycles(5);

    // Game write then read-back of cell 17.
    game_req = 1'b1; game_we = 1'b1; game_addr = 8'd17; game_wdata = 3'd5;
    applyStimulus();
    game_we = 1'b0;
    applyStimulus();
    game_req = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("raw_rvalid", 32'(obsGameRvalid), 32'd1);
    checkOutput("raw_rdata", 32'(obsGameRdata), 32'd5);

    // Starvation bound, twice to show the streak counter restarts.
    vid_addr = 8'd20;
    contendedRead(8'd33, waited);
    checkOutput("stall_wait1", 32'(waited), 32'(MAX_STALL + 1));
    vid_req = 1'b1;
    applyStimulus();
    vid_addr = vid_addr + 8'd1;
    applyStimulus();
    contendedRead(8'd34, waited);
    checkOutput("stall_wait2", 32'(waited), 32'(MAX_STALL + 1));
    idleCycles(3);

    // Alternating video / game reads of cells 0..9.
    for (int i = 0; i < 10; i++) begin
      vid_req  = (i % 2 == 0);
      game_req = (i % 2 == 1);
      game_we  = 1'b0;
      vid_addr = 8'(i);
      game_addr = 8'(i);
      applyStimulus();
    end
    idleCycles(3);

    // Reset one cycle after a video grant: that read must never return.
    vid_req = 1'b1; vid_addr = 8'd7;
    applyStimulus();
    idleCycles(3);
    vid_req = 1'b1; vid_addr = 8'd6;
    applyStimulus();
    Reset_n = 1'b0;
    #1;
    checkOutput("arst_vid_gnt", 32'(vid_gnt), 32'd0);
    checkOutput("arst_vid_rdata", 32'(vid_rdata), 32'd0);
    checkOutput("arst_game_rdata", 32'(game_rdata), 32'd0);
    rspQ.delete();
    lastVid  = '0;
    lastGame = '0;
    losses   = 0;
    applyStimulus();
    applyStimulus();
    Reset_n = 1'b1;
    idleCycles(4);

    // Randomized traffic; each requester holds its request until granted.
    vid_req  = 1'b0;
    game_req = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!vid_req || expVidGnt) begin
        vid_req  = ($urandom_range(0, 99) < 75);
        vid_addr = 8'($urandom_range(0, 255));
      end
      if (!game_req || expGameGnt) begin
        game_req   = ($urandom_range(0, 99) < 50);
        game_we    = 1'($urandom_range(0, 1));
        game_addr  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15))
                                                 : 8'($urandom_range(0, 255));
        game_wdata = 3'($urandom_range(0, 7));
      end
      expVidGnt  = 1'b0;
      expGameGnt = 1'b0;
      applyStimulus();
    end
    idleCycles(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/board_mem_arbiter.md
# board_mem_arbiter

Two-port arbiter for the single-port Tetris board RAM, which holds 10×20 cells with 3-bit colour codes. The requesters are the VGA colour mapper (read-only, hard scan deadline) and the game engine (piece lock, collision reads, line clear). The block sits between both requesters and the board RAM instance in the top level. It gives the video port fixed priority and bounds how long the game engine can be starved.

## Interface
Parameters:
- ADDR_W, 8: cell address width; 200 cells are used.
- DATA_W, 3: cell colour code width.
- MAX_STALL, 4: consecutive lost contentions after which the game port wins. Legal range 1..15.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  reset, asynchronous and active-low.
- vid_req  in  1  video read request; held until granted.
- vid_addr  in  ADDR_W  video read address.
- vid_gnt  out  1  video request accepted this cycle (combinational).
- vid_rvalid  out  1  vid_rdata valid this cycle.
- vid_rdata  out  DATA_W  video read data (registered).
- game_req  in  1  game request; held until granted.
- game_we  in  1  1 = write, 0 = read.
- game_addr  in  ADDR_W  game address.
- game_wdata  in  DATA_W  game write data.
- game_gnt  out  1  game request accepted this cycle (combinational).
- game_rvalid  out  1  game_rdata valid this cycle (reads only).
- game_rdata  out  DATA_W  game read data (registered).
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after address.

## Operation
- At most one grant per cycle. A request is retired in the cycle its gnt is high.
- Requesters must hold req, addr, we and wdata stable until gnt.
- Arbitration:
  - Only one request pending: it is granted.
  - Both pending: video wins, unless stall_cnt == MAX_STALL, in which case game wins.
- stall_cnt (4-bit):
  - Increments on each cycle where game_req=1 and vid_gnt=1.
  - Clears on game_gnt, or on any cycle with game_req=0.
  - Never exceeds MAX_STALL.
- Memory drive:
  - mem_addr, mem_we and mem_wdata are driven combinationally from the granted requester.
  - With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
  - mem_we is only ever 1 for a granted game write.
- Response pipeline uses two stages of tag registers.
  - Stage 1 records the owner (none/vid/game-read) at grant.
  - Stage 2 latches mem_rdata into the owner's rdata register and pulses that port's rvalid.
- Game writes produce no rvalid.
- Each rdata register holds its last value until its next rvalid.
- No address range check: addresses ≥ 200 pass through unchanged.

## Timing
- Grant in cycle T. rdata and rvalid are asserted in cycle T+2 for exactly one cycle.
- Full throughput: one access per cycle, with back-to-back grants allowed. Responses return in grant order.
- Reset (asynchronous, Reset_n=0):
  - stall_cnt, both pipeline tags, vid_rvalid, game_rvalid, vid_rdata and game_rdata all go to 0.
  - gnt outputs are 0 while reset is asserted.
- Reset mid-operation: in-flight responses are discarded and no rvalid follows release.
- A write and a read to the same address in consecutive cycles: the read returns the new data. This is the RAM's read-after-write behaviour, and the arbiter adds no forwarding.
- Game read with zero contention: latency is exactly 2 cycles.
- Worst-case game wait under continuous video requests: MAX_STALL cycles, then a grant on cycle MAX_STALL+1.

## Structure
- tetris_pkg holds the shared constants and types:
  - BOARD_W=10, BOARD_H=20, CELL_W=3.
  - The cell_t colour enum: EMPTY=0, I, O, T, S, Z, J, L.
  - The owner_t enum for pipeline tags: OWN_NONE, OWN_VID, OWN_GAME.
- ADDR_W and DATA_W defaults derive from the package constants.
- One sub-module, board_rsp_pipe: the 2-stage owner-tag and rdata routing pipeline. Grant logic and stall_cnt stay in the top of the block.

## Test plan
- Reset release, both req low for 5 cycles → mem_we=0, mem_addr=0, all rvalid=0, rdata=0.
- Game write addr 17 data 5 → game_gnt same cycle with mem_we=1; then a game read of addr 17 → game_rvalid 2 cycles after grant, game_rdata=5.
- vid_req held high continuously (addr incrementing), game read pending, MAX_STALL=4 → 4 vid grants, game granted on 5th cycle, then video resumes; stall_cnt returns to 0.
- Alternating vid/game reads of addresses 0..9 preloaded with colour = addr mod 8 → each port receives its own data in issue order, with no cross-routing.
- Reset_n asserted 1 cycle after a vid grant → vid_rvalid never pulses for that access; outputs return to 0 asynchronously.
- Simultaneous requests with stall_cnt < MAX_STALL → vid_gnt=1 and game_gnt=0 in the same cycle, with mem_addr = vid_addr.
